mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes mem_ir, reg_C (ALU result / effective address), dw and smdr1 (store data).
- Performs LOAD/STORE accesses on a req/ack data-memory bus and produces wb_ir and reg_C1 for write-back.
- Multi-cycle memory is supported through a stall output; a watchdog aborts hung accesses.

Parameters:
- TIMEOUT, 255: max ACCESS cycles without d_ack before abort (>=1).
- NOP_IR, 16'h0000: instruction word injected into wb_ir on abort.

Ports:
- clock  in  1  single system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- state  in  1  pipeline phase; stage advances only when state == `exec.
- mem_ir  in  16  instruction from execute stage; opcode = mem_ir[15:11].
- reg_C  in  16  ALU result / data-memory address.
- dw  in  1  store-pending flag from execute stage.
- smdr1  in  16  store data.
- d_ack  in  1  memory acknowledge; sampled only in ACCESS.
- d_rdata  in  16  load data, valid when d_ack=1.
- d_req  out  1  memory request, registered.
- d_we  out  1  write enable, registered.
- d_addr  out  16  address, registered.
- d_wdata  out  16  write data, registered.
- wb_ir  out  16  instruction to write-back.
- reg_C1  out  16  result to write-back (load data or passed reg_C).
- mem_busy  out  1  combinational stall; top level holds all upstream stages while 1.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (sync, active-high): d_req=0, d_we=0, d_addr=0, d_wdata=0, wb_ir=0, reg_C1=0, bus_err=0, counter=0, FSM=IDLE. mem_busy=0 during the reset cycle. Reset mid-ACCESS aborts the transfer: d_req drops at the reset edge and wb_ir/reg_C1 are not updated with d_rdata.
- start = (state==`exec) && (mem_ir[15:11]==`LOAD || dw).
- IDLE, state==`exec, !start: wb_ir<=mem_ir, reg_C1<=reg_C. Single-cycle passthrough; d_req stays 0.
- IDLE, start:
  - mem_busy=1 combinationally.
  - At the edge: FSM->ACCESS; d_req<=1; d_addr<=reg_C; d_we<=dw; d_wdata<=smdr1 (0 when !dw); counter<=0.
  - wb_ir and reg_C1 hold their values.
- IDLE, state!=`exec: all outputs hold.
- ACCESS: d_addr, d_we and d_wdata remain stable while d_req=1. The state input is ignored; the FSM completes regardless of state.
  - d_ack=1: mem_busy=0. At the edge:
    - wb_ir<=mem_ir
    - reg_C1<=d_rdata for LOAD, reg_C for STORE
    - d_req<=0, d_we<=0, FSM->IDLE
  - d_ack=0, counter<TIMEOUT-1: mem_busy=1; counter<=counter+1.
  - d_ack=0, counter==TIMEOUT-1 (abort): mem_busy=0. At the edge:
    - d_req<=0, d_we<=0
    - bus_err<=1
    - wb_ir<=NOP_IR, reg_C1<=0
    - FSM->IDLE
  - d_ack in the final allowed cycle wins over the timeout (normal completion, no bus_err).
- Consequences:
  - d_req is high for at most TIMEOUT cycles.
  - Access latency = 1 + k cycles, where k is the ACCESS cycle (1-based) in which d_ack is seen.
  - mem_busy is high for k cycles.
- Back-to-back accesses: a new start may be detected in the IDLE cycle immediately after completion. No bubble is required beyond that cycle.
- bus_err clears only on reset.
- Counter width: ceil(log2(TIMEOUT+1)); it never wraps.

Test Plan:
- Reset asserted 2 cycles with random inputs -> every output 0, mem_busy=0, FSM IDLE.
- mem_ir=`ADD opcode, reg_C=16'h1234, state=`exec -> next edge wb_ir=mem_ir, reg_C1=16'h1234; d_req and mem_busy never 1.
- LOAD, reg_C=16'h0040, d_ack raised in the 3rd ACCESS cycle with d_rdata=16'hBEEF:
  - d_req high exactly 3 cycles, d_addr=16'h0040, d_we=0.
  - mem_busy high 3 cycles.
  - reg_C1=16'hBEEF at the ack edge.
- STORE, dw=1, reg_C=16'h0100, smdr1=16'h5A5A, d_ack in the 1st ACCESS cycle:
  - d_we=1 and d_wdata=16'h5A5A for 1 cycle.
  - reg_C1=16'h0100, mem_busy high 1 cycle.
- TIMEOUT=4, LOAD, d_ack held 0:
  - d_req high 4 cycles.
  - bus_err=1 and stays set; wb_ir=16'h0000, reg_C1=0.
  - mem_busy drops.
  - Repeat with d_ack in the 4th cycle -> normal completion, bus_err stays 0.
- Reset asserted in the 2nd ACCESS cycle of a LOAD with d_ack=1 in the same cycle -> next edge d_req=0, reg_C1=0, bus_err=0, FSM IDLE.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: upstream pipeline inputs, write-back outputs and data-memory bus of the memory stage
interface mem_stage_if;
  logic        state;
  logic [15:0] mem_ir;
  logic [15:0] reg_C;
  logic        dw;
  logic [15:0] smdr1;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] wb_ir;
  logic [15:0] reg_C1;
  logic        mem_busy;
  logic        bus_err;
  modport slave (
    input  state, mem_ir, reg_C, dw, smdr1, d_ack, d_rdata,
    output d_req, d_we, d_addr, d_wdata, wb_ir, reg_C1, mem_busy, bus_err
  );
  modport master (
    output state, mem_ir, reg_C, dw, smdr1, d_ack, d_rdata,
    input  d_req, d_we, d_addr, d_wdata, wb_ir, reg_C1, mem_busy, bus_err
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: LOAD/STORE stage on a req/ack data bus with stall output and access watchdog
`ifndef EXEC
`define EXEC 1'b1
`endif
`ifndef LOAD
`define LOAD 5'b10001
`endif
module mem_stage #(
  parameter int          TIMEOUT = 255,
  parameter logic [15:0] NOP_IR  = 16'h0000
) (
  input logic         clock,
  input logic         reset,
  mem_stage_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, ACCESS} fsm_t;
  fsm_t        fsm_q;
  logic [CW-1:0] cnt_q;
  logic        d_req_q, d_we_q, bus_err_q;
  logic [15:0] d_addr_q, d_wdata_q, wb_ir_q, reg_c1_q;
  logic        start, expired;
  assign start   = (bus.state == `EXEC) && (bus.mem_ir[15:11] == `LOAD || bus.dw);
  assign expired = cnt_q == CW'(TIMEOUT - 1);
  assign bus.mem_busy = !reset && (fsm_q == IDLE ? start : !bus.d_ack && !expired);
  assign bus.d_req    = d_req_q;
  assign bus.d_we     = d_we_q;
  assign bus.d_addr   = d_addr_q;
  assign bus.d_wdata  = d_wdata_q;
  assign bus.wb_ir    = wb_ir_q;
  assign bus.reg_C1   = reg_c1_q;
  assign bus.bus_err  = bus_err_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q     <= IDLE;
      cnt_q     <= '0;
      d_req_q   <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      wb_ir_q   <= '0;
      reg_c1_q  <= '0;
      bus_err_q <= 1'b0;
    end else if (fsm_q == IDLE) begin
      if (start) begin
        fsm_q     <= ACCESS;
        d_req_q   <= 1'b1;
        d_addr_q  <= bus.reg_C;
        d_we_q    <= bus.dw;
        d_wdata_q <= bus.dw ? bus.smdr1 : 16'h0000;
        cnt_q     <= '0;
      end else if (bus.state == `EXEC) begin
        wb_ir_q  <= bus.mem_ir;
        reg_c1_q <= bus.reg_C;
      end
    end else if (bus.d_ack) begin
      wb_ir_q  <= bus.mem_ir;
      reg_c1_q <= d_we_q ? bus.reg_C : bus.d_rdata;
      d_req_q  <= 1'b0;
      d_we_q   <= 1'b0;
      fsm_q    <= IDLE;
    end else if (expired) begin
      wb_ir_q   <= NOP_IR;
      reg_c1_q  <= '0;
      d_req_q   <= 1'b0;
      d_we_q    <= 1'b0;
      bus_err_q <= 1'b1;
      fsm_q     <= IDLE;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with a queue scoreboard checked by a separate write-back monitor
module tb_mem_stage;
  localparam int TO = 4;
  localparam logic [15:0] IR_ADD   = 16'h0803;
  localparam logic [15:0] IR_LOAD  = 16'h8800;
  localparam logic [15:0] IR_STORE = 16'h9005;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;
  logic adv = 1'b0;
  logic [32:0] sb[$];
  mem_stage_if bus();
  mem_stage #(.TIMEOUT(TO), .NOP_IR(16'h0000)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask
  // monitor: an edge that advanced the stage is followed by a write-back compare
  always @(negedge clk) begin
    logic [32:0] e;
    if (adv) begin
      if (sb.size() == 0) chk("scoreboard underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wb_ir", {16'h0, bus.wb_ir}, {16'h0, e[32:17]});
        chk("reg_C1", {16'h0, bus.reg_C1}, {16'h0, e[16:1]});
        chk("bus_err", {31'h0, bus.bus_err}, {31'h0, e[0]});
      end
    end
    adv = !rst && !bus.mem_busy && (bus.state || bus.d_req);
  end
  task automatic pass_op(input logic [15:0] ir, input logic [15:0] c, input logic err);
    sb.push_back({ir, c, err});
    bus.state = 1'b1; bus.mem_ir = ir; bus.reg_C = c; bus.dw = 1'b0;
    @(negedge clk);
    chk("pass busy", {31'h0, bus.mem_busy}, 0);
    chk("pass req", {31'h0, bus.d_req}, 0);
    @(posedge clk); #1;
    bus.state = 1'b0;
  endtask
  task automatic access(input logic [15:0] ir, input logic [15:0] c, input logic w,
                        input logic [15:0] sd, input int k, input logic [15:0] rd, input logic err);
    int req_n, busy_n, exp_n;
    exp_n = k == 0 ? TO : k;
    sb.push_back({k == 0 ? 16'h0000 : ir, k == 0 ? 16'h0000 : (w ? c : rd), err});
    bus.state = 1'b1; bus.mem_ir = ir; bus.reg_C = c; bus.dw = w; bus.smdr1 = sd; bus.d_ack = 1'b0;
    @(negedge clk);
    chk("start busy", {31'h0, bus.mem_busy}, 1);
    chk("start req", {31'h0, bus.d_req}, 0);
    busy_n = 1; req_n = 0;
    for (int i = 1; i <= TO; i++) begin
      @(posedge clk); #1;
      bus.state = 1'b0;
      bus.d_ack = (i == k);
      bus.d_rdata = (i == k) ? rd : 16'hDEAD;
      @(negedge clk);
      req_n += int'(bus.d_req);
      busy_n += int'(bus.mem_busy);
      if (i == 1) begin
        chk("d_addr", {16'h0, bus.d_addr}, {16'h0, c});
        chk("d_we", {31'h0, bus.d_we}, {31'h0, w});
        chk("d_wdata", {16'h0, bus.d_wdata}, {16'h0, w ? sd : 16'h0000});
      end
      if (i == k) break;
    end
    @(posedge clk); #1;
    bus.d_ack = 1'b0;
    chk("req dropped", {31'h0, bus.d_req}, 0);
    chk("we dropped", {31'h0, bus.d_we}, 0);
    chk("req cycles", req_n, exp_n);
    chk("busy cycles", busy_n, exp_n);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end
  initial begin
    bus.state = 1'b1; bus.mem_ir = IR_LOAD; bus.reg_C = 16'($urandom);
    bus.dw = 1'($urandom); bus.smdr1 = 16'($urandom); bus.d_ack = 1'b1; bus.d_rdata = 16'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", {31'h0, bus.mem_busy}, 0);
    chk("rst outs", {bus.d_req, bus.d_we, bus.bus_err, bus.d_addr | bus.d_wdata | bus.wb_ir | bus.reg_C1}, 0);
    rst = 1'b0; bus.state = 1'b0; bus.d_ack = 1'b0; bus.dw = 1'b0;
    @(posedge clk); #1;
    pass_op(IR_ADD, 16'h1234, 1'b0);
    access(IR_LOAD, 16'h0040, 1'b0, 16'h0000, 3, 16'hBEEF, 1'b0);
    access(IR_STORE, 16'h0100, 1'b1, 16'h5A5A, 1, 16'h0000, 1'b0);
    access(IR_LOAD, 16'h0200, 1'b0, 16'h0000, 4, 16'hC0DE, 1'b0);
    access(IR_LOAD, 16'h0300, 1'b0, 16'h0000, 0, 16'h0000, 1'b1);
    pass_op(IR_ADD, 16'h7777, 1'b1);
    bus.state = 1'b1; bus.mem_ir = IR_LOAD; bus.reg_C = 16'h0080; bus.dw = 1'b0;
    @(posedge clk); #1;
    bus.state = 1'b0;
    @(posedge clk); #1;
    bus.d_ack = 1'b1; bus.d_rdata = 16'hBEEF; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.d_ack = 1'b0;
    chk("mid rst req", {31'h0, bus.d_req}, 0);
    chk("mid rst reg_C1", {16'h0, bus.reg_C1}, 0);
    chk("mid rst bus_err", {31'h0, bus.bus_err}, 0);
    chk("mid rst wb_ir", {16'h0, bus.wb_ir}, 0);
    @(posedge clk); #1;
    pass_op(IR_ADD, 16'h4321, 1'b0);
    repeat (3) @(posedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
